// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes emitted by the ALU control stage
// and the multi-cycle sequencer state encoding.
package alu_pkg;

  localparam int unsigned FUNC_W = 4;

  localparam logic [FUNC_W-1:0] FN_AND = 4'b0000;
  localparam logic [FUNC_W-1:0] FN_OR  = 4'b0001;
  localparam logic [FUNC_W-1:0] FN_ADD = 4'b0010;
  localparam logic [FUNC_W-1:0] FN_SUB = 4'b0110;
  localparam logic [FUNC_W-1:0] FN_SLT = 4'b0111;
  localparam logic [FUNC_W-1:0] FN_MUL = 4'b1001;
  localparam logic [FUNC_W-1:0] FN_DIV = 4'b1010;
  localparam logic [FUNC_W-1:0] FN_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative signed multiply / divide datapath on operand magnitudes.
// One shift-add (MUL) or restoring-subtract (DIV) step per 'step' cycle.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   load        capture |a|, |b|, sign and operation; clear counter
//   is_div      operation select sampled with load (1 = DIV, 0 = MUL)
//   step        advance one iteration
//   a, b        signed operands
//   last_c      current step is the last one before the final (folded) step
//   result_c    sign-corrected value after one more iteration on the current state
module muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             is_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last_c,
  output logic [WIDTH-1:0] result_c
);

  localparam int unsigned PW = 2 * WIDTH;

  // prod_q = {hi, lo}: MUL {partial sum, multiplier}, DIV {remainder, quotient}
  logic [PW-1:0]    prod_q;
  logic [PW-1:0]    prod_nx;
  logic [WIDTH-1:0] opb_q;
  logic             neg_q;
  logic             div_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic [WIDTH-1:0] low_nx;

  // Most-negative input maps to unsigned 2^(WIDTH-1), which fits WIDTH bits.
  assign abs_a  = a[WIDTH-1] ? WIDTH'(-a) : a;
  assign abs_b  = b[WIDTH-1] ? WIDTH'(-b) : b;
  assign last_c = (cnt_q == CNT_W'(WIDTH - 2));

  // Single iteration of whichever operation is loaded, plus final sign fix.
  always_comb begin
    hi       = prod_q[PW-1:WIDTH];
    lo       = prod_q[WIDTH-1:0];
    addend   = lo[0] ? opb_q : '0;
    add_sum  = {1'b0, hi} + {1'b0, addend};
    rem_sh   = {hi, lo[WIDTH-1]};
    rem_diff = rem_sh[WIDTH-1:0] - opb_q;
    if (div_q) begin
      if (rem_sh >= {1'b0, opb_q}) prod_nx = {rem_diff, lo[WIDTH-2:0], 1'b1};
      else                         prod_nx = {rem_sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
    end else begin
      prod_nx = {add_sum, lo[WIDTH-1:1]};
    end
    low_nx   = prod_nx[WIDTH-1:0];
    result_c = neg_q ? WIDTH'(-low_nx) : low_nx;
  end

  // Operand / accumulator registers and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      opb_q  <= '0;
      neg_q  <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      prod_q <= is_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
      opb_q  <= is_div ? abs_b : abs_a;
      neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
      div_q  <= is_div;
      cnt_q  <= '0;
    end else if (step) begin
      prod_q <= prod_nx;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_muldiv32.sv
// Execution-stage ALU: single-cycle AND/OR/ADD/SUB/SLT/NOR plus iterative
// signed MUL/DIV behind a start/busy/done handshake.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   start        sample func/a/b on this edge (ignored while busy)
//   func         4-bit function code (alu_pkg FN_*)
//   a, b         operands
//   result, zero registered result and (result == 0), valid with done
//   busy         MUL/DIV in progress
//   done         one-cycle completion pulse
//   div_by_zero  DIV with b == 0, updated with done
module alu_muldiv32
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [FUNC_W-1:0] func,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic             busy_d;
  logic             done_d;
  logic             dbz_d;
  logic             dz_pend_q;
  logic             dz_pend_d;
  logic [WIDTH-1:0] alu_c;
  logic             md_load;
  logic             md_step;
  logic             md_last;
  logic [WIDTH-1:0] md_result;

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (md_load),
    .is_div   (func == FN_DIV),
    .step     (md_step),
    .a        (a),
    .b        (b),
    .last_c   (md_last),
    .result_c (md_result)
  );

  // Single-cycle operations; unknown codes give 0.
  always_comb begin
    alu_c = '0;
    case (func)
      FN_AND:  alu_c = a & b;
      FN_OR:   alu_c = a | b;
      FN_ADD:  alu_c = a + b;
      FN_SUB:  alu_c = a - b;
      FN_SLT:  alu_c = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      FN_NOR:  alu_c = ~(a | b);
      default: alu_c = '0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    result_d  = result;
    zero_d    = zero;
    busy_d    = busy;
    done_d    = 1'b0;
    dbz_d     = div_by_zero;
    dz_pend_d = dz_pend_q;
    md_load   = 1'b0;
    md_step   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (func == FN_MUL || func == FN_DIV) begin
            busy_d = 1'b1;
            // Divide by zero skips iteration entirely.
            if (func == FN_DIV && b == '0) begin
              dz_pend_d = 1'b1;
              state_d   = ST_FIN;
            end else begin
              dz_pend_d = 1'b0;
              md_load   = 1'b1;
              state_d   = ST_CALC;
            end
          end else begin
            result_d = alu_c;
            zero_d   = (alu_c == '0);
            done_d   = 1'b1;
            dbz_d    = 1'b0;
          end
        end
      end
      ST_CALC: begin
        md_step = 1'b1;
        if (md_last) state_d = ST_FIN;
      end
      ST_FIN: begin
        // The final iteration is folded into this edge with the sign fix.
        result_d = dz_pend_q ? '1 : md_result;
        zero_d   = (result_d == '0);
        dbz_d    = dz_pend_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result      <= '0;
      zero        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      dz_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      result      <= result_d;
      zero        <= zero_d;
      busy        <= busy_d;
      done        <= done_d;
      div_by_zero <= dbz_d;
      dz_pend_q   <= dz_pend_d;
    end
  end

endmodule
